ws2812_driver: RTL and testbench
================================

# ws2812_driver

Serial smart-LED driver: takes the three 8-bit colour levels produced by the encoder stage (enc0 = red, enc1 = green, enc2 = blue) and streams them as WS2812-format single-wire NRZ frames. It sits beside the pwm modules as a second consumer of the encoder values, so the same knobs also control an addressable LED chain. Frames are sent automatically whenever the colour changes, on request, and once after reset.

## Interface

Parameters:
- NUM_LEDS, 1: LEDs in chain; every LED receives the same colour.
- T0H, 4: clk cycles data_out is high for a 0 bit (400 ns at 10 MHz).
- T1H, 8: clk cycles data_out is high for a 1 bit.
- BIT_CYCLES, 13: total clk cycles per bit.
- RESET_CYCLES, 600: clk cycles of low latch gap ending each frame (60 µs at 10 MHz).
- Legal: 1 <= T0H < T1H < BIT_CYCLES; RESET_CYCLES >= 1; NUM_LEDS >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- red  input  8  red level (enc0).
- green  input  8  green level (enc1).
- blue  input  8  blue level (enc2).
- start  input  1  single-cycle request to send a frame with current colour.
- data_out  output  1  serial LED data line.
- busy  output  1  high from first bit through end of latch gap.
- frame_done  output  1  one-cycle pulse when a frame (including gap) completes.

## Operation

- Registers: 24-bit snapshot {green, red, blue}; shift register; bit counter 0..23; LED counter 0..NUM_LEDS-1; cycle counter 0..max(BIT_CYCLES, RESET_CYCLES)-1; pending flag.
- States: IDLE, BIT_HIGH, BIT_LOW, GAP.
- IDLE: data_out=0, busy=0. Launch condition = pending OR start OR ({green,red,blue} != snapshot). On launch: load snapshot and shift register from current inputs, clear pending, zero counters, go BIT_HIGH.
- BIT_HIGH: data_out=1 for T1H cycles if shift MSB is 1, else T0H cycles; then BIT_LOW.
- BIT_LOW: data_out=0 for remainder so bit totals exactly BIT_CYCLES. At bit end: if bit counter < 23, shift left, next bit. Else if LED counter < NUM_LEDS-1, reload shift register from snapshot (not live inputs), bit counter to 0, next LED. Else go GAP.
- GAP: data_out=0 for RESET_CYCLES; on last cycle go IDLE and assert frame_done for exactly one cycle.
- Bit order per LED: G7..G0, R7..R0, B7..B0, MSB first.
- Inputs changing mid-frame do not affect the frame in progress; the mismatch with snapshot triggers a new frame on return to IDLE.
- start while busy sets pending; multiple starts during one frame collapse into one follow-up frame.
- Colour change and start in the same IDLE cycle: one frame only.

## Timing

- Reset values: data_out=0, busy=0, frame_done=0, state IDLE, snapshot=0, counters 0, pending=1 (one frame is sent after every reset, even with all-zero colour).
- Launch in IDLE at edge N: data_out=1 and busy=1 from edge N+1.
- Bit n of frame starts at N+1+n*BIT_CYCLES.
- Frame length (busy high) = NUM_LEDS*24*BIT_CYCLES + RESET_CYCLES cycles.
- frame_done asserted in the cycle after busy's final high cycle... precisely: on the edge where GAP ends, busy falls to 0 and frame_done rises for one cycle, concurrently.
- Earliest next launch: the cycle frame_done is high is an IDLE cycle; launch evaluated then, so back-to-back frames have a 1-cycle IDLE between gap and next bit.
- reset asserted mid-frame: next edge data_out=0, busy=0, IDLE, pending=1; frame aborted, no frame_done.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan

- After reset release with red=green=blue=0: 24 bits all 0-shaped (4 high / 9 low), 600 low cycles, frame_done once, then busy stays 0 indefinitely.
- Set green=0x80, red=0x01, blue=0xFF in IDLE: next frame bit pattern 1,0x7,0x7,1,1x8 with 8-cycle highs for 1s; busy high exactly 24*13+600=912 cycles.
- Change red to 0x55 at bit 5 of a frame: current frame still carries old red; second frame with 0x55 starts one cycle after frame_done.
- NUM_LEDS=3: same 24-bit word repeated 3 times, one 600-cycle gap, busy high 3*312+600=1536 cycles, single frame_done.
- Pulse start three times during one frame, colour unchanged: exactly one extra frame follows.
- Assert reset at bit 10: data_out 0 next cycle, no frame_done; after release a full frame with current colour is sent.

Source files
------------

// File: rtl/ws2812_driver_if.sv
// Colour/request inputs and serial line status for the WS2812 chain driver.
// The driver is the slave; whoever supplies the encoder levels is the master.
interface ws2812_driver_if;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       start;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  modport master (
    output red,
    output green,
    output blue,
    output start,
    input  data_out,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  red,
    input  green,
    input  blue,
    input  start,
    output data_out,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/ws2812_driver.sv
// WS2812 single-wire NRZ frame generator: streams {green, red, blue} MSB first to every LED
// in the chain, then holds the line low for the latch gap. Frames launch on colour change,
// on request, and once after reset.
module ws2812_driver #(
  parameter int unsigned NUM_LEDS     = 1,
  parameter int unsigned T0H          = 4,
  parameter int unsigned T1H          = 8,
  parameter int unsigned BIT_CYCLES   = 13,
  parameter int unsigned RESET_CYCLES = 600
) (
  input logic            clk,
  input logic            reset,
  ws2812_driver_if.slave bus
);

  localparam int unsigned CycMax = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;
  localparam int unsigned LedW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CycW-1:0] T0hEnd  = CycW'(T0H - 1);
  localparam logic [CycW-1:0] T1hEnd  = CycW'(T1H - 1);
  localparam logic [CycW-1:0] BitEnd  = CycW'(BIT_CYCLES - 1);
  localparam logic [CycW-1:0] GapEnd  = CycW'(RESET_CYCLES - 1);
  localparam logic [LedW-1:0] LedEnd  = LedW'(NUM_LEDS - 1);
  localparam logic [4:0]      LastBit = 5'd23;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBitHigh = 2'd1;
  localparam logic [1:0] StBitLow  = 2'd2;
  localparam logic [1:0] StGap     = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [23:0]     snapshot_q, snapshot_d;
  logic [23:0]     shift_q, shift_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [LedW-1:0] led_cnt_q, led_cnt_d;
  logic [CycW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic            pending_q, pending_d;
  logic            data_out_q, data_out_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [23:0]     colour;
  logic            launch;
  logic [CycW-1:0] high_end;

  // Wire order is green first, so the snapshot is kept in that order too.
  assign colour   = {bus.green, bus.red, bus.blue};
  assign launch   = pending_q | bus.start | (colour != snapshot_q);
  assign high_end = shift_q[23] ? T1hEnd : T0hEnd;

  always_comb begin
    state_d      = state_q;
    snapshot_d   = snapshot_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    led_cnt_d    = led_cnt_q;
    cyc_cnt_d    = cyc_cnt_q + CycW'(1);
    frame_done_d = 1'b0;
    // Requests arriving mid-frame collapse into a single follow-up frame.
    pending_d    = pending_q | (bus.start & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        cyc_cnt_d = '0;
        if (launch) begin
          snapshot_d = colour;
          shift_d    = colour;
          pending_d  = 1'b0;
          bit_cnt_d  = '0;
          led_cnt_d  = '0;
          state_d    = StBitHigh;
        end
      end

      StBitHigh: begin
        if (cyc_cnt_q == high_end) begin
          state_d = StBitLow;
        end
      end

      StBitLow: begin
        if (cyc_cnt_q == BitEnd) begin
          cyc_cnt_d = '0;
          state_d   = StBitHigh;
          if (bit_cnt_q != LastBit) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            shift_d   = {shift_q[22:0], 1'b0};
          end else if (led_cnt_q != LedEnd) begin
            // Every LED gets the latched colour, never the live inputs.
            led_cnt_d = led_cnt_q + LedW'(1);
            bit_cnt_d = '0;
            shift_d   = snapshot_q;
          end else begin
            state_d = StGap;
          end
        end
      end

      StGap: begin
        if (cyc_cnt_q == GapEnd) begin
          cyc_cnt_d    = '0;
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end

      default: begin
        cyc_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase

    // Outputs follow the next state so they register alongside it.
    data_out_d = (state_d == StBitHigh);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      snapshot_q   <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      led_cnt_q    <= '0;
      cyc_cnt_q    <= '0;
      pending_q    <= 1'b1;
      data_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snapshot_q   <= snapshot_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      led_cnt_q    <= led_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      pending_q    <= pending_d;
      data_out_q   <= data_out_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: decodes the serial line back into 24-bit words and checks them
// against a queue of expected frames; one single-LED and one three-LED instance.
module tb_ws2812_driver;

  localparam int T0H = 4;
  localparam int T1H = 8;
  localparam int BIT = 13;
  localparam int GAP = 600;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic [7:0] red, green, blue;
  logic       start;

  always #5 clk = ~clk;

  ws2812_driver_if bus1 ();
  ws2812_driver_if bus3 ();

  assign bus1.red   = red;
  assign bus1.green = green;
  assign bus1.blue  = blue;
  assign bus1.start = start;
  assign bus3.red   = red;
  assign bus3.green = green;
  assign bus3.blue  = blue;
  assign bus3.start = start;

  ws2812_driver #(.NUM_LEDS(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  ws2812_driver #(.NUM_LEDS(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  int          frames = 0;
  bit          sel = 1'b0;
  bit          mon_en = 1'b0;
  bit          expect_b2b = 1'b0;
  bit          expect_abort = 1'b0;

  logic mon_data, mon_busy, mon_fd;
  assign mon_data = sel ? bus3.data_out : bus1.data_out;
  assign mon_busy = sel ? bus3.busy : bus1.busy;
  assign mon_fd   = sel ? bus3.frame_done : bus1.frame_done;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line decoder: a bit closes when data rises again; the last bit's low run includes the gap.
  int          hi = 0, lo = 0, nbits = 0, busy_cnt = 0, idle_cnt = 0, leds;
  bit          prev_busy = 1'b0, shape_bad = 1'b0;
  logic [71:0] word = '0;
  logic [23:0] w;

  always @(negedge clk) begin
    if (mon_en) begin
      leds = sel ? 3 : 1;
      if (mon_busy && !prev_busy) begin
        if (expect_b2b) begin
          chk("b2b_idle_cycles", idle_cnt, 1);
          expect_b2b = 1'b0;
        end
        hi = 0; lo = 0; nbits = 0; busy_cnt = 0; shape_bad = 1'b0; word = '0;
      end
      if (mon_busy) begin
        busy_cnt++;
        if (mon_data) begin
          if (lo != 0) begin
            if (!(hi == T0H || hi == T1H) || (hi + lo != BIT)) shape_bad = 1'b1;
            word = {word[70:0], (hi == T1H)};
            nbits++;
            hi = 0;
            lo = 0;
          end
          hi++;
        end else begin
          lo++;
        end
      end else if (!prev_busy) begin
        idle_cnt++;
      end

      if (!mon_busy && prev_busy) begin
        idle_cnt = 1;
        chk("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) w = exp_q.pop_front();
        if (expect_abort) begin
          chk("abort_no_frame_done", mon_fd, 0);
          expect_abort = 1'b0;
        end else begin
          if (!(hi == T0H || hi == T1H)) shape_bad = 1'b1;
          chk("gap_len", lo, BIT - hi + GAP);
          word = {word[70:0], (hi == T1H)};
          nbits++;
          chk("bit_shape_bad", shape_bad, 0);
          chk("bit_count", nbits, 24 * leds);
          chk("busy_len", busy_cnt, leds * 24 * BIT + GAP);
          chk("frame_done", mon_fd, 1);
          for (int i = 0; i < leds; i++) begin
            chk("led_word", word[(leds - 1 - i) * 24 +: 24], w);
          end
          frames++;
        end
      end else if (mon_fd) begin
        chk("spurious_frame_done", mon_fd, 0);
      end
      prev_busy = mon_busy;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frames_reached", frames, target);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!mon_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", mon_busy, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int nf;
    rst1 = 1'b1; rst3 = 1'b1;
    red = 8'h00; green = 8'h00; blue = 8'h00; start = 1'b0;
    idle(3);
    chk("rst_data_out", bus1.data_out, 0);
    chk("rst_busy", bus1.busy, 0);
    chk("rst_frame_done", bus1.frame_done, 0);
    mon_en = 1'b1;

    // Reset always yields one frame, even with an all-zero colour.
    exp_q.push_back(24'h000000);
    rst1 = 1'b0;
    wait_frames(1, 2000);
    idle(1500);
    chk("post_reset_quiet", frames, 1);
    chk("post_reset_busy", mon_busy, 0);
    nf = 1;

    // Colour change in idle.
    @(negedge clk);
    green = 8'h80; red = 8'h01; blue = 8'hFF;
    exp_q.push_back(24'h8001FF);
    wait_frames(nf + 1, 2000);
    nf++;

    // Mid-frame change: current frame keeps old red, follow-up starts one idle cycle later.
    @(negedge clk);
    red = 8'h33;
    exp_q.push_back(24'h8033FF);
    wait_busy(10);
    idle(5 * BIT);
    red = 8'h55;
    exp_q.push_back(24'h8055FF);
    expect_b2b = 1'b1;
    wait_frames(nf + 2, 3000);
    nf += 2;

    // Start with unchanged colour, then three starts mid-frame collapse into one.
    exp_q.push_back(24'h8055FF);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_busy", mon_busy, 1);
    chk("start_latency_data", mon_data, 1);
    idle(50);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      idle(20);
    end
    exp_q.push_back(24'h8055FF);
    wait_frames(nf + 2, 3000);
    nf += 2;
    idle(1200);
    chk("starts_collapsed", frames, nf);

    // Colour change and start in the same idle cycle: one frame only.
    @(negedge clk);
    green = 8'h12;
    start = 1'b1;
    exp_q.push_back(24'h1255FF);
    @(negedge clk);
    start = 1'b0;
    wait_frames(nf + 1, 2000);
    nf++;
    idle(1200);
    chk("change_and_start_single", frames, nf);

    // Reset at bit 10 aborts the frame; a fresh frame follows release.
    @(negedge clk);
    blue = 8'hA5;
    exp_q.push_back(24'h1255A5);
    wait_busy(10);
    idle(10 * BIT + 2);
    expect_abort = 1'b1;
    rst1 = 1'b1;
    @(negedge clk);
    chk("abort_data_out", bus1.data_out, 0);
    chk("abort_busy", bus1.busy, 0);
    rst1 = 1'b0;
    exp_q.push_back(24'h1255A5);
    wait_frames(nf + 1, 2000);
    nf++;
    idle(1200);
    chk("after_abort_single", frames, nf);

    // Three-LED chain: same word three times, one gap, one frame_done.
    @(negedge clk);
    rst1 = 1'b1;
    sel  = 1'b1;
    green = 8'hC3; red = 8'h3C; blue = 8'h5A;
    idle(2);
    exp_q.push_back(24'hC33C5A);
    rst3 = 1'b0;
    wait_frames(nf + 1, 3000);
    nf++;
    idle(2000);
    chk("chain_quiet", frames, nf);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
